sccb_config_sequencer: RTL

Walks a camera register table and writes each `{reg, value}` entry to the OV7670 over a write-only 3-phase SCCB bus. The sequencer indexes an external combinational config LUT (16-bit `{reg[15:8], val[7:0]}` entries), serialises each entry, and generates SIOC/SIOD with open-drain SIOD control. It supports configurable table depth and bus rate, in-table delay and end markers, hole skipping, and optional ACK-phase monitoring. It sits between the top-level power-up/reset logic and the camera pins.

---
 rtl/sccb_config_sequencer_if.sv | 44 ++++
 rtl/sccb_config_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_config_sequencer_if.sv
// ---------------------------------------------------------------------------
// sccb_config_sequencer_if
//
// Bundles the sequencer's control, LUT and SCCB pad signals.
//   master : the sequencer (drives lut_index, sioc, siod_o/oe, status)
//   slave  : system/camera side (drives start, lut_data, siod_i)
//
// Signals
//   start        one-cycle pulse, begins a sweep from index 0 when idle
//   lut_index    current table index
//   lut_data     combinational LUT entry {reg[15:8], val[7:0]}
//   sioc         SCCB clock
//   siod_o       SIOD drive value (always 0)
//   siod_oe      1 = pull SIOD low, 0 = release to the pull-up
//   siod_i       SIOD pad readback
//   busy / done  sweep in progress / sweep finished
//   write_count  bus writes completed this sweep
//   nack_count   don't-care bits sampled high (saturating)
// ---------------------------------------------------------------------------
interface sccb_config_sequencer_if #(
  parameter int IDX_W = 8
) ();
  logic             start;
  logic [IDX_W-1:0] lut_index;
  logic [15:0]      lut_data;
  logic             sioc;
  logic             siod_o;
  logic             siod_oe;
  logic             siod_i;
  logic             busy;
  logic             done;
  logic [IDX_W-1:0] write_count;
  logic [7:0]       nack_count;

  modport master (
    input  start, lut_data, siod_i,
    output lut_index, sioc, siod_o, siod_oe, busy, done, write_count, nack_count
  );

  modport slave (
    output start, lut_data, siod_i,
    input  lut_index, sioc, siod_o, siod_oe, busy, done, write_count, nack_count
  );
endinterface

// File: rtl/sccb_config_sequencer.sv
// ---------------------------------------------------------------------------
// sccb_config_sequencer
//
// Walks an external combinational register table and writes each
// {reg, value} entry to an OV7670 over the write-only 3-phase SCCB bus.
// Table entries 16'hFFFF end the sweep, 16'hFExx insert a delay of
// xx*DELAY_UNIT cycles, and 16'h0000 is skipped when SKIP_ZERO is set.
//
// Ports
//   clk    system clock
//   reset  asynchronous, active-high reset
//   bus    sccb_config_sequencer_if.master (LUT, SCCB pads, status)
// ---------------------------------------------------------------------------
module sccb_config_sequencer #(
  parameter int         IDX_W      = 8,
  parameter int         ROM_DEPTH  = 168,
  parameter logic [7:0] DEV_ADDR   = 8'h42,
  parameter int         QTR        = 125,
  parameter int         GAP_CYCLES = 1000,
  parameter int         DELAY_UNIT = 100000,
  parameter bit         SKIP_ZERO  = 1'b1,
  parameter bit         CHECK_ACK  = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  sccb_config_sequencer_if.master bus
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_DELAY  = 4'd3;
  localparam logic [3:0] S_START  = 4'd4;
  localparam logic [3:0] S_BITS   = 4'd5;
  localparam logic [3:0] S_STOP   = 4'd6;
  localparam logic [3:0] S_GAP    = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam int QW = $clog2(QTR);

  logic [3:0]       state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [IDX_W-1:0] wcnt_q,    wcnt_d;
  logic [7:0]       nack_q,    nack_d;
  logic [15:0]      entry_q,   entry_d;
  logic [26:0]      shreg_q,   shreg_d;
  logic [QW-1:0]    qcnt_q,    qcnt_d;
  logic [1:0]       quarter_q, quarter_d;
  logic [4:0]       bit_q,     bit_d;
  logic [31:0]      wait_q,    wait_d;
  logic             sioc_q,    sioc_d;
  logic             oe_q,      oe_d;
  logic             advance;
  logic             q_end;
  logic             ack_bit;

  assign q_end   = (qcnt_q == QW'(QTR - 1));
  // Don't-care (ACK) slots follow each byte: bit counts 8, 17 and 26.
  assign ack_bit = (bit_q == 5'd8) || (bit_q == 5'd17) || (bit_q == 5'd26);

  // Pad levels for a given phase: returns {sioc, siod_oe}. The data bit is
  // held on siod_oe for all four quarters so SIOD only moves while SIOC is
  // low; X bits are stored as 1 so they release the line like a 1 bit.
  function automatic logic [1:0] bus_drive(input logic [3:0] st,
                                           input logic [1:0] q,
                                           input logic       b);
    case (st)
      S_START: bus_drive = 2'b11;
      S_BITS:  bus_drive = {(q == 2'd1) || (q == 2'd2), ~b};
      S_STOP:  bus_drive = {(q != 2'd0), (q != 2'd2)};
      default: bus_drive = 2'b10;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    nack_d    = nack_q;
    entry_d   = entry_q;
    shreg_d   = shreg_q;
    qcnt_d    = qcnt_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    wait_d    = wait_q;
    advance   = 1'b0;

    if (state_q == S_START || state_q == S_BITS || state_q == S_STOP)
      qcnt_d = q_end ? '0 : qcnt_q + 1'b1;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          idx_d   = '0;
          wcnt_d  = '0;
          nack_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        entry_d = bus.lut_data;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (entry_q == 16'hFFFF) begin
          state_d = S_DONE;
        end else if (entry_q[15:8] == 8'hFE) begin
          if (entry_q[7:0] == 8'h00) begin
            advance = 1'b1;
          end else begin
            wait_d  = 32'(entry_q[7:0]) * 32'(DELAY_UNIT) - 32'd1;
            state_d = S_DELAY;
          end
        end else if (SKIP_ZERO && entry_q == 16'h0000) begin
          advance = 1'b1;
        end else begin
          shreg_d   = {DEV_ADDR, 1'b1, entry_q[15:8], 1'b1, entry_q[7:0], 1'b1};
          qcnt_d    = '0;
          quarter_d = 2'd0;
          state_d   = S_START;
        end
      end
      S_DELAY, S_GAP: begin
        if (wait_q == 32'd0) advance = 1'b1;
        else                 wait_d  = wait_q - 32'd1;
      end
      S_START: begin
        if (q_end) begin
          if (quarter_q == 2'd1) begin
            quarter_d = 2'd0;
            bit_d     = 5'd0;
            state_d   = S_BITS;
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end
      S_BITS: begin
        // Sample at the end of the SIOC-high window; a high reading is only
        // counted, the sweep carries on regardless.
        if (CHECK_ACK && ack_bit && quarter_q == 2'd2 && q_end &&
            bus.siod_i && nack_q != 8'hFF)
          nack_d = nack_q + 8'd1;
        if (q_end) begin
          if (quarter_q == 2'd3) begin
            quarter_d = 2'd0;
            if (bit_q == 5'd26) begin
              state_d = S_STOP;
            end else begin
              bit_d   = bit_q + 5'd1;
              shreg_d = {shreg_q[25:0], 1'b1};
            end
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end
      S_STOP: begin
        if (q_end) begin
          if (quarter_q == 2'd2) begin
            quarter_d = 2'd0;
            wcnt_d    = wcnt_q + 1'b1;
            if (GAP_CYCLES == 0) begin
              advance = 1'b1;
            end else begin
              wait_d  = 32'(GAP_CYCLES - 1);
              state_d = S_GAP;
            end
          end else begin
            quarter_d = quarter_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == IDX_W'(ROM_DEPTH - 1)) begin
        state_d = S_DONE;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_FETCH;
      end
    end

    // Pads are registered from the next state so they never glitch.
    {sioc_d, oe_d} = bus_drive(state_d, quarter_d, shreg_d[26]);
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the entry/shift datapath is reset too; it costs little and
      // keeps the pads and X-propagation deterministic after a mid-frame reset.
      state_q   <= S_IDLE;
      idx_q     <= '0;
      wcnt_q    <= '0;
      nack_q    <= '0;
      entry_q   <= '0;
      shreg_q   <= '0;
      qcnt_q    <= '0;
      quarter_q <= 2'd0;
      bit_q     <= 5'd0;
      wait_q    <= 32'd0;
      sioc_q    <= 1'b1;
      oe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      wcnt_q    <= wcnt_d;
      nack_q    <= nack_d;
      entry_q   <= entry_d;
      shreg_q   <= shreg_d;
      qcnt_q    <= qcnt_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      wait_q    <= wait_d;
      sioc_q    <= sioc_d;
      oe_q      <= oe_d;
    end
  end

  assign bus.lut_index   = idx_q;
  assign bus.sioc        = sioc_q;
  assign bus.siod_o      = 1'b0;
  assign bus.siod_oe     = oe_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.write_count = wcnt_q;
  assign bus.nack_count  = nack_q;

endmodule
